// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN          - default instruction / PC width
//   NOP_INSTR     - instruction presented when no fetch is available (ADDI x0,x0,0)
//   fetch_entry_t - {pc, instr} pair as held in the prefetch queue
package if_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with single-cycle clear, used for the fetch tag queue and
// the {pc, instr} prefetch queue.
//   clk, rst   - clock, synchronous active-high reset
//   clr        - empties the FIFO this cycle; push/pop in the same cycle are ignored
//   push       - write push_data (must not be asserted while full)
//   pop        - drop the head entry; ignored when empty
//   head_data  - current head entry (valid when count != 0)
//   count      - number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop, full;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    do_push  = push && !clr;
    do_pop   = pop && !clr && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
    if (!rst) begin
      assert (!(do_push && full));
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: PC generator, decoupled request/response
// instruction-memory port and a DEPTH-entry prefetch queue feeding ID.
//   clk, rst                         - clock, synchronous active-high reset
//   redirect_valid, redirect_pc      - flush and restart fetch at redirect_pc
//   imem_req_valid/ready/addr        - fetch request channel (word aligned)
//   imem_rsp_valid/data              - in-order response channel, one per request
//   out_valid/ready, out_instr/pc    - instruction stream towards ID
// Build option: define IF_PREFETCH_BYPASS_EN to let a response arriving at an
// empty queue reach the outputs in the same cycle.
module if_prefetch #(
  parameter int unsigned           XLEN      = if_pkg::XLEN,
  parameter int unsigned           DEPTH     = 4,
  parameter logic [XLEN-1:0]       RESET_PC  = '0,
  parameter logic [XLEN-1:0]       NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int unsigned     CW         = $clog2(DEPTH + 1);
  localparam int unsigned     EW         = 2 * XLEN;
  localparam logic [XLEN-1:0] RESET_PC_A = RESET_PC & ~XLEN'(3);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   data_count, tag_count;
  logic [EW-1:0]   data_head;
  logic [XLEN-1:0] tag_head;
  logic [CW:0]     occupancy;
  logic            req_fire, rsp_live, bypass, data_push, data_pop;
  logic            unused_tag_count;

  assign unused_tag_count = ^tag_count;

  // Credit covers both buffered and in-flight fetches, so every response
  // is guaranteed a free queue slot.
  always_comb begin
    occupancy      = {1'b0, data_count} + {1'b0, inflight_q};
    imem_req_valid = !rst && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // Responses owed to pre-redirect requests are counted down in drop_q.
    rsp_live       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
`ifdef IF_PREFETCH_BYPASS_EN
    bypass         = rsp_live && (data_count == '0);
`else
    bypass         = 1'b0;
`endif
    out_valid      = (data_count != '0) || bypass;
    data_push      = rsp_live && !(bypass && out_ready);
    data_pop       = (data_count != '0) && out_ready && !redirect_valid;
    out_instr      = NOP_INSTR;
    out_pc         = '0;
    if (bypass) begin
      out_instr = imem_rsp_data;
      out_pc    = tag_head;
    end else if (out_valid) begin
      out_instr = data_head[XLEN-1:0];
      out_pc    = data_head[EW-1:XLEN];
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      drop_d     = inflight_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC_A;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  if_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (rsp_live),
    .head_data (tag_head),
    .count     (tag_count)
  );

  if_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (redirect_valid),
    .push      (data_push),
    .push_data ({tag_head, imem_rsp_data}),
    .pop       (data_pop),
    .head_data (data_head),
    .count     (data_count)
  );

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;
  import if_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  if_prefetch #(
    .XLEN      (32),
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned epoch;
  } mreq_t;

  mreq_t        pend[$];   // memory model: requests not yet answered
  fetch_entry_t sb[$];     // expected instruction stream since last redirect
  int unsigned  cyc = 0, epoch = 0, occ = 0, req_total = 0;
  int unsigned  mem_lat = 1, ready_pct = 100;
  logic [31:0]  exp_addr = RESET_PC;
  int           n_vec = 0, n_err = 0;
  bit           live, pop, exp_rv, exp_ov;
  fetch_entry_t e;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: fixed latency per request, in order, one response per cycle.
  always @(negedge clk) begin
    cyc++;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    #3;
    if (rst) begin
      chk("req_valid_in_reset", {31'b0, imem_req_valid}, 32'd0);
      pend.delete();
      sb.delete();
      occ      = 0;
      epoch++;
      exp_addr = RESET_PC;
    end else begin
      live   = imem_rsp_valid && pend.size() > 0 && pend[0].epoch == epoch && !redirect_valid;
      exp_rv = !redirect_valid && (occ + pend.size() < DEPTH);
      exp_ov = (occ > 0) || (BYP && live);
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
      if (!out_valid) begin
        chk("idle_instr", out_instr, 32'h0000_0013);
        chk("idle_pc", out_pc, 32'd0);
      end
      pop = out_valid && out_ready && !redirect_valid;
      if (pop) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got pc %h, expected no instruction (cycle %0d)", out_pc, cyc);
        end else begin
          e = sb.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", out_instr, e.instr);
        end
      end
      if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_addr);
        pend.push_back(mreq_t'{addr: exp_addr, due: cyc + mem_lat, epoch: epoch});
        sb.push_back(fetch_entry_t'{pc: exp_addr, instr: word(exp_addr)});
        exp_addr  = exp_addr + 32'd4;
        req_total++;
      end
      if (redirect_valid) begin
        occ = 0;
        sb.delete();
        epoch++;
        exp_addr = {redirect_pc[31:2], 2'b00};
      end else begin
        occ = occ + (live ? 1 : 0);
        if (pop && occ > 0) occ = occ - 1;
      end
    end
  end

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  int unsigned r0;
  bit          seen;

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Streaming from RESET_PC with a 1-cycle memory.
    repeat (30) @(negedge clk);

    // Stall ID: only DEPTH fetches may be accepted, then drain in order.
    out_ready = 1'b0;
    do_redirect(32'h0000_0200);
    r0 = req_total;
    repeat (10) @(negedge clk);
    chk("stall_req_count", req_total - r0, DEPTH);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);

    // 3-cycle memory: redirect with three fetches outstanding.
    mem_lat = 3;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (pend.size() == 3) seen = 1'b1;
    end
    chk("three_inflight_reached", {31'b0, seen}, 32'd1);
    do_redirect(32'h0000_0100);
    repeat (15) @(negedge clk);

    // Redirect coinciding with a response while ID is accepting.
    mem_lat = 1;
    repeat (8) @(negedge clk);
    do_redirect(32'h0000_0340);
    repeat (8) @(negedge clk);
    do_redirect(32'h0000_0400);
    do_redirect(32'h0000_0500);
    repeat (8) @(negedge clk);

    // Reset mid-stream with a non-empty queue.
    out_ready = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);

    // Unaligned target near the top of the address space (wraps to 0).
    do_redirect(32'hFFFF_FFF6);
    repeat (12) @(negedge clk);

    // Randomised traffic.
    ready_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) mem_lat = $urandom_range(4, 1);
      out_ready = ($urandom_range(99) < 75);
      if ($urandom_range(99) < 3) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom & 32'h0000_FFFF;
      end else begin
        redirect_valid = 1'b0;
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    ready_pct      = 100;
    repeat (20) @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
